// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the board I/O controller.
//   page_e       display page encoding (P0..P3)
//   DEF_W*       default cost weights
//   SEG_HEX      hex digit to active-low segment pattern {g..a}, dp kept off
//   seg_decode   nibble + decimal-point request to full {dp,g..a} pattern
package board_pkg;

  typedef enum logic [1:0] {
    PAGE_P0 = 2'd0,
    PAGE_P1 = 2'd1,
    PAGE_P2 = 2'd2,
    PAGE_P3 = 2'd3
  } page_e;

  localparam int DEF_WA_UP  = 2;
  localparam int DEF_WA_DN  = 1;
  localparam int DEF_WA_BRK = 4;
  localparam int DEF_WB_UP  = 4;
  localparam int DEF_WB_DN  = 1;
  localparam int DEF_WB_BRK = 2;

  localparam logic [7:0] SEL_RESET = 8'hFE;

  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Segments are active-low, so a lit decimal point drives bit 7 low.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib, input logic dp_on);
    logic [7:0] pat;
    pat = SEG_HEX[nib];
    return {~dp_on, pat[6:0]};
  endfunction

endpackage

// File: rtl/seg_scan.sv
// seg_scan: multiplexed 8-digit 7-segment scanner.
//   clk, rst_n  clock and asynchronous active-low reset
//   word        32-bit value to show, digit i = word[4i+3:4i]
//   dp_req      light the decimal point of digit 0
//   seg         registered segment pattern {dp,g..a}, active-low
//   sel         registered one-hot active-low digit select
module seg_scan
  import board_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word,
  input  logic        dp_req,
  output logic [7:0]  seg,
  output logic [7:0]  sel
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dig_q, dig_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       sel_q, sel_d;
  logic [3:0]       nib_s;

  // Dwell counter, digit index and the decoded pattern for the digit about to be shown.
  always_comb begin
    cnt_d = cnt_q;
    dig_d = dig_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = {CNT_W{1'b0}};
      dig_d = dig_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      dig_d = dig_q;
    end
    // Decode from the next index so seg and sel flip on the same edge.
    nib_s = word[{dig_d, 2'b00} +: 4];
    sel_d = ~(8'd1 << dig_d);
    seg_d = seg_decode(nib_s, dp_req && (dig_d == 3'd0));
  end

  // Scan state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
      dig_q <= 3'd0;
      seg_q <= SEG_HEX[0];
      sel_q <= SEL_RESET;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign seg = seg_q;
  assign sel = sel_q;

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: board-level glue between switches/buttons, CPU core and 7-seg display.
//   in_clk/in_rst         clock, asynchronous active-low reset
//   in_data/in_cfg_sel    switch data and target config register
//   in_cfg_btn            config write button, in_page_btn page-advance button (async)
//   in_hold               freeze the displayed word
//   in_up_floor .. in_attempt_cnt   CPU result counters
//   out_cfg               packed config words, out_cpu_ce CPU clock-enable pulse
//   out_cost_a/b          saturated weighted costs (2-cycle pipeline)
//   out_page              current page, out_seg/out_sel display drive
module board_io_ctrl
  import board_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_CFG  = 4,
  parameter int SEL_W    = $clog2(NUM_CFG),
  parameter int DIV_LOG2 = 2,
  parameter int SCAN_DIV = 100000,
  parameter int WA_UP    = DEF_WA_UP,
  parameter int WA_DN    = DEF_WA_DN,
  parameter int WA_BRK   = DEF_WA_BRK,
  parameter int WB_UP    = DEF_WB_UP,
  parameter int WB_DN    = DEF_WB_DN,
  parameter int WB_BRK   = DEF_WB_BRK
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_cfg_sel,
  input  logic                      in_cfg_btn,
  input  logic                      in_page_btn,
  input  logic                      in_hold,
  input  logic [DATA_W-1:0]         in_up_floor,
  input  logic [DATA_W-1:0]         in_down_floor,
  input  logic [DATA_W-1:0]         in_broken_cnt,
  input  logic [31:0]               in_attempt_cnt,
  output logic [NUM_CFG*DATA_W-1:0] out_cfg,
  output logic                      out_cpu_ce,
  output logic [DATA_W-1:0]         out_cost_a,
  output logic [DATA_W-1:0]         out_cost_b,
  output logic [1:0]                out_page,
  output logic [7:0]                out_seg,
  output logic [7:0]                out_sel
);

  localparam int BTN_CFG  = 0;
  localparam int BTN_PAGE = 1;
  localparam int P_W      = DATA_W + 3;  // product of a DATA_W value and a weight <= 7
  localparam int S_W      = DATA_W + 5;  // sum of three products

  logic [1:0]          btn_raw_s, btn_meta_q, btn_sync_q, btn_prev_q, btn_rise_s;
  logic [DATA_W-1:0]   cfg_q [NUM_CFG];
  logic [DATA_W-1:0]   cfg_d [NUM_CFG];
  logic [DIV_LOG2-1:0] div_q, div_d;
  logic                ce_q, ce_d;
  logic [P_W-1:0]      pa_q [3];
  logic [P_W-1:0]      pb_q [3];
  logic [P_W-1:0]      pa_d [3];
  logic [P_W-1:0]      pb_d [3];
  logic [S_W-1:0]      sum_a_s, sum_b_s;
  logic [DATA_W-1:0]   cost_a_q, cost_a_d, cost_b_q, cost_b_d;
  page_e               page_q, page_d;
  logic [31:0]         page_word_s, snap_q, snap_d;

  assign btn_raw_s = {in_page_btn, in_cfg_btn};

  // Both buttons share one synchroniser/edge path; a held button yields a single rise.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      btn_meta_q <= 2'b00;
      btn_sync_q <= 2'b00;
      btn_prev_q <= 2'b00;
    end else begin
      btn_meta_q <= btn_raw_s;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  assign btn_rise_s = btn_sync_q & ~btn_prev_q;

  // Config write, packing, CE divider and both cost pipeline stages.
  always_comb begin
    out_cfg = {(NUM_CFG*DATA_W){1'b0}};
    for (int i = 0; i < NUM_CFG; i++) begin
      // A select with no matching register simply writes nothing.
      if (btn_rise_s[BTN_CFG] && (in_cfg_sel == SEL_W'(i))) begin
        cfg_d[i] = in_data;
      end else begin
        cfg_d[i] = cfg_q[i];
      end
      out_cfg[i*DATA_W +: DATA_W] = cfg_q[i];
    end

    div_d = div_q + DIV_LOG2'(1);
    // Registered compare against the next count keeps the pulse aligned with the all-ones count.
    ce_d  = (div_d == {DIV_LOG2{1'b1}});

    pa_d[0] = P_W'(in_up_floor)   * P_W'(WA_UP);
    pa_d[1] = P_W'(in_down_floor) * P_W'(WA_DN);
    pa_d[2] = P_W'(in_broken_cnt) * P_W'(WA_BRK);
    pb_d[0] = P_W'(in_up_floor)   * P_W'(WB_UP);
    pb_d[1] = P_W'(in_down_floor) * P_W'(WB_DN);
    pb_d[2] = P_W'(in_broken_cnt) * P_W'(WB_BRK);

    sum_a_s = S_W'(pa_q[0]) + S_W'(pa_q[1]) + S_W'(pa_q[2]);
    sum_b_s = S_W'(pb_q[0]) + S_W'(pb_q[1]) + S_W'(pb_q[2]);
    if (|sum_a_s[S_W-1:DATA_W]) begin
      cost_a_d = {DATA_W{1'b1}};
    end else begin
      cost_a_d = sum_a_s[DATA_W-1:0];
    end
    if (|sum_b_s[S_W-1:DATA_W]) begin
      cost_b_d = {DATA_W{1'b1}};
    end else begin
      cost_b_d = sum_b_s[DATA_W-1:0];
    end
  end

  // Config, divider and cost registers.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_q[i] <= {DATA_W{1'b0}};
      end
      for (int i = 0; i < 3; i++) begin
        pa_q[i] <= {P_W{1'b0}};
        pb_q[i] <= {P_W{1'b0}};
      end
      div_q    <= {DIV_LOG2{1'b0}};
      ce_q     <= 1'b0;
      cost_a_q <= {DATA_W{1'b0}};
      cost_b_q <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_q[i] <= cfg_d[i];
      end
      for (int i = 0; i < 3; i++) begin
        pa_q[i] <= pa_d[i];
        pb_q[i] <= pb_d[i];
      end
      div_q    <= div_d;
      ce_q     <= ce_d;
      cost_a_q <= cost_a_d;
      cost_b_q <= cost_b_d;
    end
  end

  // Page FSM next state, page word selection and hold-gated snapshot.
  always_comb begin
    page_d = page_q;
    if (btn_rise_s[BTN_PAGE]) begin
      case (page_q)
        PAGE_P0: page_d = PAGE_P1;
        PAGE_P1: page_d = PAGE_P2;
        PAGE_P2: page_d = PAGE_P3;
        PAGE_P3: page_d = PAGE_P0;
        default: page_d = PAGE_P0;
      endcase
    end else begin
      page_d = page_q;
    end

    case (page_q)
      PAGE_P0: page_word_s = {16'(cost_a_q), 16'(cost_b_q)};
      PAGE_P1: page_word_s = {16'(in_up_floor), 16'(in_down_floor)};
      PAGE_P2: page_word_s = {16'(cfg_q[0]), 16'(cfg_q[1])};
      PAGE_P3: page_word_s = in_attempt_cnt;
      default: page_word_s = 32'h0000_0000;
    endcase

    if (in_hold) begin
      snap_d = snap_q;
    end else begin
      snap_d = page_word_s;
    end
  end

  // Page state and display snapshot registers.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      page_q <= PAGE_P0;
      snap_q <= 32'h0000_0000;
    end else begin
      page_q <= page_d;
      snap_q <= snap_d;
    end
  end

  seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk    (in_clk),
    .rst_n  (in_rst),
    .word   (snap_q),
    .dp_req (in_hold),
    .seg    (out_seg),
    .sel    (out_sel)
  );

  assign out_cpu_ce = ce_q;
  assign out_cost_a = cost_a_q;
  assign out_cost_b = cost_b_q;
  assign out_page   = page_q;

endmodule
